// File: rtl/hdlc_rx_line_monitor.sv
// HDLC receive-line monitor: per-channel flag/abort/idle/frame classification
// with saturating per-channel event counters read back through a select mux.
//
// Ports:
//   Clk, Rst        clock, asynchronous active-high reset
//   Rx, Rx_En       serial bit and bit strobe per channel
//   Clr             synchronous clear of a channel's three counters
//   Sel             channel select for counter readout (out of range reads 0)
//   FlagDetect      pulse: flag 01111110 completed
//   AbortDetect     pulse: ones run reached ABORT_LEN
//   Idle            level: ones run at IDLE_LEN
//   InFrame         level: channel inside a frame payload
//   FrameOk         pulse: valid frame closed
//   FrameErr        pulse: short, misaligned or oversized frame closed
//   AbortInFrame    pulse: abort inside a frame payload
//   FrameOkCnt, FrameErrCnt, AbortCnt   counters of channel Sel
module hdlc_rx_line_monitor #(
  parameter int CH        = 4,
  parameter int CNT_W     = 16,
  parameter int LEN_W     = 12,
  parameter int ABORT_LEN = 7,
  parameter int IDLE_LEN  = 15,
  parameter int MIN_BITS  = 8
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic [CH-1:0]                      Rx,
  input  logic [CH-1:0]                      Rx_En,
  input  logic [CH-1:0]                      Clr,
  input  logic [((CH>1)?$clog2(CH):1)-1:0]   Sel,
  output logic [CH-1:0]                      FlagDetect,
  output logic [CH-1:0]                      AbortDetect,
  output logic [CH-1:0]                      Idle,
  output logic [CH-1:0]                      InFrame,
  output logic [CH-1:0]                      FrameOk,
  output logic [CH-1:0]                      FrameErr,
  output logic [CH-1:0]                      AbortInFrame,
  output logic [CNT_W-1:0]                   FrameOkCnt,
  output logic [CNT_W-1:0]                   FrameErrCnt,
  output logic [CNT_W-1:0]                   AbortCnt
);

  localparam int RUN_W = $clog2(IDLE_LEN + 1);
  localparam logic [RUN_W-1:0] R_STUFF = RUN_W'(5);
  localparam logic [RUN_W-1:0] R_AB1   = RUN_W'(ABORT_LEN - 1);
  localparam logic [RUN_W-1:0] R_IDLE  = RUN_W'(IDLE_LEN);

  typedef enum logic [1:0] {HUNT, OPEN, DATA} state_t;

  logic [CNT_W-1:0] ok_arr  [CH];
  logic [CNT_W-1:0] err_arr [CH];
  logic [CNT_W-1:0] ab_arr  [CH];

  function automatic logic [CNT_W-1:0] cnt_next(
    input logic [CNT_W-1:0] v,
    input logic             clr,
    input logic             inc
  );
    // A clear coinciding with an increment keeps that event: result is 1.
    if (clr) return inc ? CNT_W'(1) : '0;
    if (inc && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_t           state, state_n;
    logic [7:0]       sr, sr_n;
    logic [RUN_W-1:0] run, run_n;
    logic [LEN_W-1:0] bcnt, bcnt_n, pay;
    logic             stuffed, flag, abort, good;
    logic             ok, err, aif;
    logic             flag_q, abort_q, idle_q, ok_q, err_q, aif_q;
    logic [CNT_W-1:0] ok_cnt, err_cnt, ab_cnt;

    always_comb begin
      // A 0 after five ones is a zero-deleted bit: invisible to flag
      // matching and to the length count.
      stuffed = ~Rx[c] && (run == R_STUFF);
      sr_n    = stuffed ? sr : {sr[6:0], Rx[c]};
      if (!Rx[c])            run_n = '0;
      else if (run == R_IDLE) run_n = run;
      else                    run_n = run + RUN_W'(1);
      flag  = Rx_En[c] && !stuffed && (sr_n == 8'h7E);
      abort = Rx_En[c] && Rx[c] && (run == R_AB1);
      if (flag)                       bcnt_n = '0;
      else if (stuffed || bcnt == '1) bcnt_n = bcnt;
      else                            bcnt_n = bcnt + LEN_W'(1);
      // bcnt still includes the first 7 bits of the closing flag.
      pay  = bcnt - LEN_W'(7);
      good = (pay >= LEN_W'(MIN_BITS)) && (pay[2:0] == 3'd0) &&
             (bcnt != '1);
    end

    always_comb begin
      state_n = state;
      ok      = 1'b0;
      err     = 1'b0;
      aif     = 1'b0;
      if (Rx_En[c]) begin
        unique case (state)
          HUNT: if (flag) state_n = OPEN;
          OPEN: begin
            if (abort)                        state_n = HUNT;
            else if (flag)                    state_n = OPEN;
            else if (bcnt_n == LEN_W'(8))     state_n = DATA;
          end
          DATA: begin
            if (abort) begin
              aif     = 1'b1;
              state_n = HUNT;
            end else if (flag) begin
              ok      = good;
              err     = ~good;
              state_n = OPEN;
            end
          end
          default: state_n = HUNT;
        endcase
      end
    end

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        state   <= HUNT;
        sr      <= '0;
        run     <= '0;
        bcnt    <= '0;
        idle_q  <= 1'b0;
        flag_q  <= 1'b0;
        abort_q <= 1'b0;
        ok_q    <= 1'b0;
        err_q   <= 1'b0;
        aif_q   <= 1'b0;
      end else begin
        state   <= state_n;
        flag_q  <= flag;
        abort_q <= abort;
        ok_q    <= ok;
        err_q   <= err;
        aif_q   <= aif;
        if (Rx_En[c]) begin
          sr     <= sr_n;
          run    <= run_n;
          bcnt   <= bcnt_n;
          idle_q <= (run_n == R_IDLE);
        end
      end
    end

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        ok_cnt  <= '0;
        err_cnt <= '0;
        ab_cnt  <= '0;
      end else begin
        ok_cnt  <= cnt_next(ok_cnt, Clr[c], ok);
        err_cnt <= cnt_next(err_cnt, Clr[c], err);
        ab_cnt  <= cnt_next(ab_cnt, Clr[c], aif);
      end
    end

    assign FlagDetect[c]   = flag_q;
    assign AbortDetect[c]  = abort_q;
    assign Idle[c]         = idle_q;
    assign InFrame[c]      = (state == DATA);
    assign FrameOk[c]      = ok_q;
    assign FrameErr[c]     = err_q;
    assign AbortInFrame[c] = aif_q;
    assign ok_arr[c]       = ok_cnt;
    assign err_arr[c]      = err_cnt;
    assign ab_arr[c]       = ab_cnt;
  end

  always_comb begin
    FrameOkCnt  = '0;
    FrameErrCnt = '0;
    AbortCnt    = '0;
    for (int c = 0; c < CH; c++) begin
      if (int'(Sel) == c) begin
        FrameOkCnt  = ok_arr[c];
        FrameErrCnt = err_arr[c];
        AbortCnt    = ab_arr[c];
      end
    end
  end

endmodule

// File: tb/tb_hdlc_rx_line_monitor.sv
// Directed bench for hdlc_rx_line_monitor: flags, good/stuffed/short frames,
// abort and idle, counter clear, async reset and strobe-gated hold.
module tb_hdlc_rx_line_monitor;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [3:0]  Rx, Rx_En, Clr;
  logic [1:0]  Sel;
  logic [3:0]  FlagDetect, AbortDetect, Idle, InFrame;
  logic [3:0]  FrameOk, FrameErr, AbortInFrame;
  logic [15:0] FrameOkCnt, FrameErrCnt, AbortCnt;

  int errors = 0;
  int checks = 0;

  hdlc_rx_line_monitor dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_En(Rx_En), .Clr(Clr), .Sel(Sel),
    .FlagDetect(FlagDetect), .AbortDetect(AbortDetect), .Idle(Idle),
    .InFrame(InFrame), .FrameOk(FrameOk), .FrameErr(FrameErr),
    .AbortInFrame(AbortInFrame), .FrameOkCnt(FrameOkCnt),
    .FrameErrCnt(FrameErrCnt), .AbortCnt(AbortCnt)
  );

  always #5 Clk = ~Clk;

  // Sends n bits MSB first on one channel; outputs are sampled 1 time unit
  // after the edge that accepted the last bit.
  task automatic send_bits(input int ch, input logic [31:0] bits,
                           input int n, input logic clr_last);
    for (int i = n - 1; i >= 0; i--) begin
      Rx[ch]    = bits[i];
      Rx_En     = 4'b0;
      Rx_En[ch] = 1'b1;
      Clr       = (i == 0 && clr_last) ? (4'b1 << ch) : 4'b0;
      @(posedge Clk); #1;
    end
    Rx_En = 4'b0;
    Clr   = 4'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Rx = 4'b0; Rx_En = 4'b0; Clr = 4'b0; Sel = 2'd0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({FlagDetect, AbortDetect, Idle, InFrame, FrameOk, FrameErr,
         AbortInFrame} !== 28'h0) begin
      errors++;
      $display("FAIL reset_flags: got %h want 0", {FlagDetect, AbortDetect,
               Idle, InFrame, FrameOk, FrameErr, AbortInFrame});
    end
    checks++;
    if ({FrameOkCnt, FrameErrCnt, AbortCnt} !== 48'h0) begin
      errors++;
      $display("FAIL reset_cnts: got %h want 0",
               {FrameOkCnt, FrameErrCnt, AbortCnt});
    end
    Rst = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_flag();
    send_bits(0, 32'h7E, 8, 1'b0);
    checks++;
    if (FlagDetect !== 4'b0001) begin
      errors++;
      $display("FAIL flag_pulse: got %b want 0001", FlagDetect);
    end
    checks++;
    if ({InFrame, AbortDetect, FrameOk, FrameErr} !== 16'h0) begin
      errors++;
      $display("FAIL flag_others: got %h want 0",
               {InFrame, AbortDetect, FrameOk, FrameErr});
    end
    @(posedge Clk); #1;
    checks++;
    if (FlagDetect !== 4'b0000) begin
      errors++;
      $display("FAIL flag_width: got %b want 0000", FlagDetect);
    end
  endtask

  task automatic test_good_frame();
    send_bits(0, 32'h7E, 8, 1'b0);
    send_bits(0, 32'hA5, 8, 1'b0);
    checks++;
    if (InFrame !== 4'b0001) begin
      errors++;
      $display("FAIL good_inframe: got %b want 0001", InFrame);
    end
    send_bits(0, 32'h3C, 8, 1'b0);
    send_bits(0, 32'h7E, 8, 1'b0);
    checks++;
    if ({FrameOk, FrameErr, FlagDetect} !== 12'h101) begin
      errors++;
      $display("FAIL good_close: got %h want 101",
               {FrameOk, FrameErr, FlagDetect});
    end
    checks++;
    if (InFrame !== 4'b0000) begin
      errors++;
      $display("FAIL good_inframe_drop: got %b want 0000", InFrame);
    end
    Sel = 2'd0;
    #1;
    checks++;
    if (FrameOkCnt !== 16'd1) begin
      errors++;
      $display("FAIL good_cnt: got %0d want 1", FrameOkCnt);
    end
    @(posedge Clk); #1;
    checks++;
    if (FrameOk !== 4'b0000) begin
      errors++;
      $display("FAIL good_width: got %b want 0000", FrameOk);
    end
  endtask

  task automatic test_stuffed();
    send_bits(0, 32'b111110111, 9, 1'b0);
    checks++;
    if (InFrame !== 4'b0001) begin
      errors++;
      $display("FAIL stuff_inframe: got %b want 0001", InFrame);
    end
    send_bits(0, 32'h7E, 8, 1'b0);
    checks++;
    if ({FrameOk, FrameErr} !== 8'h10) begin
      errors++;
      $display("FAIL stuff_close: got %h want 10", {FrameOk, FrameErr});
    end
    #1;
    checks++;
    if ({FrameOkCnt, FrameErrCnt} !== {16'd2, 16'd0}) begin
      errors++;
      $display("FAIL stuff_cnts: got %0d/%0d want 2/0",
               FrameOkCnt, FrameErrCnt);
    end
  endtask

  task automatic test_abort();
    send_bits(2, 32'h7E, 8, 1'b0);
    checks++;
    if (FlagDetect !== 4'b0100) begin
      errors++;
      $display("FAIL abort_flag: got %b want 0100", FlagDetect);
    end
    send_bits(2, 32'hAA, 8, 1'b0);
    checks++;
    if (InFrame !== 4'b0100) begin
      errors++;
      $display("FAIL abort_inframe: got %b want 0100", InFrame);
    end
    send_bits(2, 32'h7F, 8, 1'b0);
    checks++;
    if ({AbortDetect, AbortInFrame, InFrame} !== 12'h440) begin
      errors++;
      $display("FAIL abort_pulse: got %h want 440",
               {AbortDetect, AbortInFrame, InFrame});
    end
    Sel = 2'd2;
    #1;
    checks++;
    if (AbortCnt !== 16'd1) begin
      errors++;
      $display("FAIL abort_cnt: got %0d want 1", AbortCnt);
    end
    send_bits(2, 32'h7F, 7, 1'b0);
    checks++;
    if ({Idle, AbortDetect} !== 8'h00) begin
      errors++;
      $display("FAIL idle_early: got %h want 00", {Idle, AbortDetect});
    end
    send_bits(2, 32'h1, 1, 1'b0);
    checks++;
    if (Idle !== 4'b0100) begin
      errors++;
      $display("FAIL idle_set: got %b want 0100", Idle);
    end
    send_bits(2, 32'h0, 1, 1'b0);
    checks++;
    if (Idle !== 4'b0000) begin
      errors++;
      $display("FAIL idle_clear: got %b want 0000", Idle);
    end
  endtask

  task automatic test_short_frame();
    Sel = 2'd0;
    send_bits(0, 32'b1010101010, 10, 1'b0);
    send_bits(0, 32'h7E, 8, 1'b0);
    checks++;
    if ({FrameOk, FrameErr} !== 8'h01) begin
      errors++;
      $display("FAIL short_close: got %h want 01", {FrameOk, FrameErr});
    end
    #1;
    checks++;
    if (FrameErrCnt !== 16'd1) begin
      errors++;
      $display("FAIL short_cnt: got %0d want 1", FrameErrCnt);
    end
    send_bits(0, 32'b1010101010, 10, 1'b0);
    send_bits(0, 32'h7E, 8, 1'b1);
    checks++;
    if (FrameErr !== 4'b0001) begin
      errors++;
      $display("FAIL clr_pulse: got %b want 0001", FrameErr);
    end
    #1;
    checks++;
    if ({FrameErrCnt, FrameOkCnt} !== {16'd1, 16'd0}) begin
      errors++;
      $display("FAIL clr_inc: got %0d/%0d want 1/0",
               FrameErrCnt, FrameOkCnt);
    end
    Sel = 2'd3;
    #1;
    checks++;
    if ({FrameOkCnt, FrameErrCnt, AbortCnt} !== 48'h0) begin
      errors++;
      $display("FAIL sel3_cnts: got %h want 0",
               {FrameOkCnt, FrameErrCnt, AbortCnt});
    end
  endtask

  task automatic test_reset_midframe();
    send_bits(1, 32'h7E, 8, 1'b0);
    send_bits(1, 32'hAA, 8, 1'b0);
    checks++;
    if (InFrame !== 4'b0010) begin
      errors++;
      $display("FAIL mid_inframe: got %b want 0010", InFrame);
    end
    #2 Rst = 1'b1;
    #1;
    Sel = 2'd2;
    #1;
    checks++;
    if ({InFrame, FlagDetect, FrameOk, FrameErr, AbortCnt} !== 32'h0) begin
      errors++;
      $display("FAIL async_rst: got %h want 0",
               {InFrame, FlagDetect, FrameOk, FrameErr, AbortCnt});
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
    send_bits(1, 32'hCC, 8, 1'b0);
    send_bits(1, 32'h7E, 8, 1'b0);
    checks++;
    if ({FlagDetect, FrameOk, FrameErr, InFrame} !== 16'h2000) begin
      errors++;
      $display("FAIL mid_discard: got %h want 2000",
               {FlagDetect, FrameOk, FrameErr, InFrame});
    end
  endtask

  task automatic test_hold();
    int bad;
    send_bits(0, 32'h7E, 8, 1'b0);
    send_bits(0, 32'hA5, 8, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      Rx    = (i % 2 == 1) ? 4'hF : 4'h0;
      Rx_En = 4'b0;
      @(posedge Clk); #1;
      if ({FlagDetect, AbortDetect, Idle, FrameOk, FrameErr, AbortInFrame,
           InFrame} !== 28'h0000001) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_quiet: got %0d bad cycles want 0", bad);
    end
    send_bits(0, 32'h3C, 8, 1'b0);
    send_bits(0, 32'h7E, 8, 1'b0);
    checks++;
    if ({FrameOk, FrameErr} !== 8'h10) begin
      errors++;
      $display("FAIL hold_resume: got %h want 10", {FrameOk, FrameErr});
    end
    Sel = 2'd0;
    #1;
    checks++;
    if (FrameOkCnt !== 16'd1) begin
      errors++;
      $display("FAIL hold_cnt: got %0d want 1", FrameOkCnt);
    end
  endtask

  initial begin
    test_reset();
    test_flag();
    test_good_frame();
    test_stuffed();
    test_abort();
    test_short_frame();
    test_reset_midframe();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
